// File: rtl/reg_writeback_if.sv
// reg_writeback_if: result inputs, register-file write port and bypass lookups of the writeback unit
interface reg_writeback_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_rd;
  logic [DATA_W-1:0] ld_data;
  logic              reg_we;
  logic [ADDR_W-1:0] dstreg_num;
  logic [DATA_W-1:0] dstreg_data;
  logic [ADDR_W-1:0] byp1_num;
  logic              byp1_hit;
  logic [DATA_W-1:0] byp1_data;
  logic [ADDR_W-1:0] byp2_num;
  logic              byp2_hit;
  logic [DATA_W-1:0] byp2_data;
  logic              wb_idle;
  modport master (
    output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, byp1_num, byp2_num,
    input  alu_ready, ld_ready, reg_we, dstreg_num, dstreg_data,
    input  byp1_hit, byp1_data, byp2_hit, byp2_data, wb_idle
  );
  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, byp1_num, byp2_num,
    output alu_ready, ld_ready, reg_we, dstreg_num, dstreg_data,
    output byp1_hit, byp1_data, byp2_hit, byp2_data, wb_idle
  );
endinterface

// File: rtl/reg_writeback_unit.sv
// reg_writeback_unit: in-order write queue feeding the register file write port, with two bypass lookups
module reg_writeback_unit #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input logic clk,
  input logic rst,
  reg_writeback_if.slave wb
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  logic [ADDR_W-1:0] r_q_rd   [DEPTH];
  logic [DATA_W-1:0] r_q_data [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic              r_we;
  logic [ADDR_W-1:0] r_num;
  logic [DATA_W-1:0] r_data;
  logic              w_ready;
  logic              w_ld_en;
  logic              w_alu_en;
  logic              w_deq;
  logic [PTR_W-1:0]  w_alu_ptr;
  logic [DATA_W:0]   w_byp1;
  logic [DATA_W:0]   w_byp2;
  // Two free slots are always kept so both sources can be accepted in one cycle
  assign w_ready   = (CNT_W'(DEPTH) - r_count) >= CNT_W'(2);
  assign w_ld_en   = wb.ld_valid && w_ready && (wb.ld_rd != '0);
  assign w_alu_en  = wb.alu_valid && w_ready && (wb.alu_rd != '0);
  assign w_deq     = r_count != '0;
  assign w_alu_ptr = r_tail + PTR_W'(w_ld_en);
  // Youngest matching candidate wins: output register first, then queue oldest to youngest overrides
  function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] num);
    logic [DATA_W:0]  res;
    logic [PTR_W-1:0] idx;
    res = (r_we && r_num == num) ? {1'b1, r_data} : '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = r_head + PTR_W'(i);
      if (CNT_W'(i) < r_count && r_q_rd[idx] == num) res = {1'b1, r_q_data[idx]};
    end
    return (num == '0) ? '0 : res;
  endfunction
  // Bypass lookups see registered state only
  always_comb begin
    w_byp1 = lookup(wb.byp1_num);
    w_byp2 = lookup(wb.byp2_num);
  end
  // Queue storage: load entry goes in first so the ALU entry is younger
  always_ff @(posedge clk) begin
    if (w_ld_en) begin
      r_q_rd[r_tail]   <= wb.ld_rd;
      r_q_data[r_tail] <= wb.ld_data;
    end
    if (w_alu_en) begin
      r_q_rd[w_alu_ptr]   <= wb.alu_rd;
      r_q_data[w_alu_ptr] <= wb.alu_data;
    end
  end
  // Pointers wrap naturally; count moves by enqueues minus the dequeue
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PTR_W'(w_deq);
      r_tail  <= r_tail + PTR_W'(w_ld_en) + PTR_W'(w_alu_en);
      r_count <= r_count + CNT_W'(w_ld_en) + CNT_W'(w_alu_en) - CNT_W'(w_deq);
    end
  end
  // Register-file write port: head moves out every cycle the queue is non-empty
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we   <= 1'b0;
      r_num  <= '0;
      r_data <= '0;
    end else begin
      r_we <= w_deq;
      if (w_deq) begin
        r_num  <= r_q_rd[r_head];
        r_data <= r_q_data[r_head];
      end
    end
  end
  assign wb.alu_ready   = w_ready;
  assign wb.ld_ready    = w_ready;
  assign wb.reg_we      = r_we;
  assign wb.dstreg_num  = r_num;
  assign wb.dstreg_data = r_data;
  assign wb.byp1_hit    = w_byp1[DATA_W];
  assign wb.byp1_data   = w_byp1[DATA_W-1:0];
  assign wb.byp2_hit    = w_byp2[DATA_W];
  assign wb.byp2_data   = w_byp2[DATA_W-1:0];
  assign wb.wb_idle     = (r_count == '0) && !r_we;
endmodule

// File: tb/tb_reg_writeback_unit.sv
// tb_reg_writeback_unit: directed and random stimulus checked against a queue-based reference model
module tb_reg_writeback_unit;
  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } ent_t;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  ent_t mq[$];
  logic m_we;
  ent_t m_out;
  always #5 clk = ~clk;
  reg_writeback_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) wb ();
  reg_writeback_unit #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk),
    .rst(rst),
    .wb (wb)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [DATA_W:0] model_byp(input logic [ADDR_W-1:0] num);
    if (num == '0) return '0;
    for (int i = mq.size() - 1; i >= 0; i--)
      if (mq[i].rd == num) return {1'b1, mq[i].data};
    if (m_we && m_out.rd == num) return {1'b1, m_out.data};
    return '0;
  endfunction
  task automatic step(input logic lv, input logic [ADDR_W-1:0] lrd, input logic [DATA_W-1:0] ldat,
                      input logic av, input logic [ADDR_W-1:0] ard, input logic [DATA_W-1:0] adat,
                      input logic [ADDR_W-1:0] b1, input logic [ADDR_W-1:0] b2);
    logic rdy;
    wb.ld_valid  = lv;
    wb.ld_rd     = lrd;
    wb.ld_data   = ldat;
    wb.alu_valid = av;
    wb.alu_rd    = ard;
    wb.alu_data  = adat;
    wb.byp1_num  = b1;
    wb.byp2_num  = b2;
    #1;
    rdy = (DEPTH - mq.size()) >= 2;
    check("alu_ready", 64'(wb.alu_ready), 64'(rdy));
    check("ld_ready", 64'(wb.ld_ready), 64'(rdy));
    check("byp1", 64'({wb.byp1_hit, wb.byp1_data}), 64'(model_byp(b1)));
    check("byp2", 64'({wb.byp2_hit, wb.byp2_data}), 64'(model_byp(b2)));
    @(posedge clk);
    if (mq.size() > 0) begin
      m_we  = 1'b1;
      m_out = mq.pop_front();
    end else m_we = 1'b0;
    if (lv && rdy && lrd != '0) mq.push_back({lrd, ldat});
    if (av && rdy && ard != '0) mq.push_back({ard, adat});
    @(negedge clk);
    check("reg_we", 64'(wb.reg_we), 64'(m_we));
    check("dstreg_num", 64'(wb.dstreg_num), 64'(m_out.rd));
    check("dstreg_data", 64'(wb.dstreg_data), 64'(m_out.data));
    check("wb_idle", 64'(wb.wb_idle), 64'(mq.size() == 0 && !m_we));
    check("count_bound", 64'(dut.r_count <= DEPTH), 64'(1));
  endtask
  task automatic idle(input int n, input logic [ADDR_W-1:0] b1);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, '0, b1, '0);
  endtask
  function automatic logic [ADDR_W-1:0] rrd();
    return ADDR_W'($urandom_range(0, 7));
  endfunction
  initial begin
    rst = 1'b0;
    m_we = 1'b0;
    m_out = '0;
    step(1'b0, '0, '0, 1'b0, '0, '0, '0, '0);
    rst = 1'b1;
    idle(5, '0);
    // single ALU write, bypass visible while pending, gone afterwards
    step(1'b0, '0, '0, 1'b1, 5'd3, 32'h1234_5678, 5'd3, '0);
    idle(3, 5'd3);
    // same-cycle load and ALU to the same register: ALU value is younger
    step(1'b1, 5'd5, 32'hAAAA_0000, 1'b1, 5'd5, 32'h0000_BBBB, 5'd5, 5'd5);
    for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b0, '0, '0, 5'd5, 5'd5);
    // writes to register 0 are swallowed
    step(1'b1, '0, 32'hDEAD_BEEF, 1'b1, '0, 32'hCAFE_F00D, '0, '0);
    idle(2, '0);
    // both sources every cycle: backpressure and ordering
    for (int i = 0; i < 20; i++)
      step(1'b1, ADDR_W'(2 * i % 31 + 1), DATA_W'(32'h100 + 2 * i), 1'b1, ADDR_W'((2 * i + 1) % 31 + 1),
           DATA_W'(32'h101 + 2 * i), ADDR_W'(2 * i % 31 + 1), ADDR_W'((2 * i + 1) % 31 + 1));
    idle(6, '0);
    // pointer wrap with gapped single writes
    for (int i = 0; i < 3 * DEPTH; i++) begin
      step(1'b0, '0, '0, 1'b1, ADDR_W'(i % 7 + 1), $urandom, ADDR_W'(i % 7 + 1), '0);
      idle(1, ADDR_W'(i % 7 + 1));
    end
    idle(3, '0);
    // asynchronous reset with entries queued
    step(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, '0, '0);
    step(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, '0, '0);
    check("queued_before_reset", 64'(wb.wb_idle), 64'(0));
    wb.ld_valid = 1'b0;
    wb.alu_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("rst_reg_we", 64'(wb.reg_we), 64'(0));
    check("rst_idle", 64'(wb.wb_idle), 64'(1));
    check("rst_num", 64'(wb.dstreg_num), 64'(0));
    mq.delete();
    m_we = 1'b0;
    m_out = '0;
    @(negedge clk);
    rst = 1'b1;
    idle(3, 5'd3);
    // random traffic with collisions and zero destinations
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), rrd(), $urandom, 1'($urandom_range(0, 1)), rrd(), $urandom, rrd(), rrd());
    idle(DEPTH + 2, '0);
    check("final_idle", 64'(wb.wb_idle), 64'(1));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
